// File: rtl/traffic_pkg.sv
// Shared lamp codes, phase encoding and width helper for the traffic-light family.
package traffic_pkg;

  localparam logic [1:0] LIGHT_GREEN  = 2'b00;
  localparam logic [1:0] LIGHT_YELLOW = 2'b01;
  localparam logic [1:0] LIGHT_RED    = 2'b10;
  localparam logic [1:0] LIGHT_OFF    = 2'b11;

  typedef enum logic [1:0] {
    GREEN  = 2'b00,
    YELLOW = 2'b01,
    ALLRED = 2'b10,
    FLASH  = 2'b11
  } phase_t;

  // Index width for a set of n ways; never narrower than one bit.
  function automatic int unsigned way_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: next requesting way after active, or way 0 on restart.
module rr_pick
  import traffic_pkg::*;
#(
  parameter int unsigned N_WAYS = 2
) (
  input  logic [N_WAYS-1:0]         req,
  input  logic [way_w(N_WAYS)-1:0]  active,
  input  logic                      restart,
  output logic [way_w(N_WAYS)-1:0]  grant
);

  localparam int unsigned AW = way_w(N_WAYS);

  logic [AW-1:0] idx;
  logic          found;

  // Scan active+1, active+2, ... and take the first requester; hold active if none.
  always_comb begin
    grant = active;
    idx   = '0;
    found = 1'b0;
    for (int unsigned off = 1; off < N_WAYS; off++) begin
      idx = AW'((32'(active) + off) % N_WAYS);
      if (!found && req[idx]) begin
        grant = idx;
        found = 1'b1;
      end
    end
    if (restart) begin
      grant = '0;
    end
  end

endmodule

// File: rtl/traffic_light_ctrl.sv
// Multi-way round-robin traffic-light controller with timed phases and flash mode.
module traffic_light_ctrl
  import traffic_pkg::*;
#(
  parameter int unsigned N_WAYS    = 2,
  parameter int unsigned GREEN_MIN = 4,
  parameter int unsigned GREEN_MAX = 8,
  parameter int unsigned YELLOW_T  = 2,
  parameter int unsigned ALLRED_T  = 1,
  parameter int unsigned FLASH_T   = 3,
  parameter int unsigned CNT_W     = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_WAYS-1:0]         req,
  input  logic                      flash,
  output logic [2*N_WAYS-1:0]       light,
  output logic [way_w(N_WAYS)-1:0]  active_way,
  output logic [1:0]                phase
);

  localparam int unsigned AW = way_w(N_WAYS);

  localparam logic [CNT_W-1:0] GMIN_LAST  = CNT_W'(GREEN_MIN - 1);
  localparam logic [CNT_W-1:0] GMAX_LAST  = CNT_W'(GREEN_MAX - 1);
  localparam logic [CNT_W-1:0] YEL_LAST   = CNT_W'(YELLOW_T - 1);
  localparam logic [CNT_W-1:0] AR_LAST    = CNT_W'(ALLRED_T - 1);
  localparam logic [CNT_W-1:0] FLASH_LAST = CNT_W'(FLASH_T - 1);

  phase_t          phase_q, phase_d;
  logic [AW-1:0]   active_q, active_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic            blink_q, blink_d;
  logic            restart_q, restart_d;

  logic [AW-1:0]   grant;
  logic            other_req;
  logic            own_req;

  rr_pick #(
    .N_WAYS (N_WAYS)
  ) u_rr_pick (
    .req     (req),
    .active  (active_q),
    .restart (restart_q),
    .grant   (grant)
  );

  // State register; synchronous reset to way 0 green.
  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q   <= GREEN;
      active_q  <= '0;
      timer_q   <= '0;
      blink_q   <= 1'b0;
      restart_q <= 1'b0;
    end else begin
      phase_q   <= phase_d;
      active_q  <= active_d;
      timer_q   <= timer_d;
      blink_q   <= blink_d;
      restart_q <= restart_d;
    end
  end

  // Request summary: active way's own sensor and any competing sensor.
  always_comb begin
    other_req = 1'b0;
    own_req   = 1'b0;
    for (int unsigned k = 0; k < N_WAYS; k++) begin
      if (AW'(k) == active_q) begin
        own_req = req[k];
      end else begin
        other_req = other_req | req[k];
      end
    end
  end

  // Next-state: flash overrides sequencing; timer clears on every phase change.
  always_comb begin
    phase_d   = phase_q;
    active_d  = active_q;
    blink_d   = blink_q;
    restart_d = restart_q;
    timer_d   = (timer_q == {CNT_W{1'b1}}) ? timer_q : timer_q + CNT_W'(1);

    if (flash) begin
      if (phase_q != FLASH) begin
        phase_d = FLASH;
        timer_d = '0;
        blink_d = 1'b0;
      end else if (timer_q == FLASH_LAST) begin
        blink_d = ~blink_q;
        timer_d = '0;
      end
    end else begin
      unique case (phase_q)
        GREEN: begin
          if (timer_q >= GMIN_LAST && other_req &&
              (!own_req || timer_q >= GMAX_LAST)) begin
            phase_d = YELLOW;
            timer_d = '0;
          end
        end
        YELLOW: begin
          if (timer_q == YEL_LAST) begin
            phase_d = ALLRED;
            timer_d = '0;
          end
        end
        ALLRED: begin
          if (timer_q == AR_LAST) begin
            phase_d   = GREEN;
            timer_d   = '0;
            active_d  = grant;
            restart_d = 1'b0;
          end
        end
        FLASH: begin
          phase_d   = ALLRED;
          timer_d   = '0;
          restart_d = 1'b1;
        end
        default: begin
          phase_d = GREEN;
          timer_d = '0;
        end
      endcase
    end
  end

  // Lamp decode from registered state only.
  always_comb begin
    light = '0;
    for (int unsigned k = 0; k < N_WAYS; k++) begin
      light[2*k +: 2] = LIGHT_RED;
      unique case (phase_q)
        GREEN:   if (AW'(k) == active_q) light[2*k +: 2] = LIGHT_GREEN;
        YELLOW:  if (AW'(k) == active_q) light[2*k +: 2] = LIGHT_YELLOW;
        FLASH:   light[2*k +: 2] = blink_q ? LIGHT_OFF : LIGHT_YELLOW;
        default: light[2*k +: 2] = LIGHT_RED;
      endcase
    end
  end

  assign active_way = active_q;
  assign phase      = phase_q;

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Directed self-checking bench for traffic_light_ctrl with three ways.
module tb_traffic_light_ctrl;

  localparam int unsigned N = 3;

  localparam logic [5:0] L_G0 = 6'b10_10_00;
  localparam logic [5:0] L_G1 = 6'b10_00_10;
  localparam logic [5:0] L_G2 = 6'b00_10_10;
  localparam logic [5:0] L_Y0 = 6'b10_10_01;
  localparam logic [5:0] L_AR = 6'b10_10_10;
  localparam logic [5:0] L_FY = 6'b01_01_01;
  localparam logic [5:0] L_FO = 6'b11_11_11;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] req;
  logic       flash;
  logic [5:0] light;
  logic [1:0] active_way;
  logic [1:0] phase;

  int tests = 0;
  int fails = 0;

  traffic_light_ctrl #(
    .N_WAYS    (N),
    .GREEN_MIN (4),
    .GREEN_MAX (8),
    .YELLOW_T  (2),
    .ALLRED_T  (1),
    .FLASH_T   (3),
    .CNT_W     (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .flash      (flash),
    .light      (light),
    .active_way (active_way),
    .phase      (phase)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench at cycle 0: reset state visible, rst released for the next edge.
  task automatic do_reset(input logic [2:0] r);
    rst   = 1'b1;
    flash = 1'b0;
    req   = r;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; flash = 1'b1; req = 3'b111;
    step();
    step();
    tests++;
    if (phase !== 2'b00) begin fails++; $display("FAIL reset phase got %b want 00", phase); end
    tests++;
    if (active_way !== 2'd0) begin fails++; $display("FAIL reset active got %0d want 0", active_way); end
    tests++;
    if (light !== L_G0) begin fails++; $display("FAIL reset light got %b want %b", light, L_G0); end
    flash = 1'b0;
  endtask

  task automatic test_idle_hold();
    do_reset(3'b000);
    for (int c = 0; c < 20; c++) begin
      tests++;
      if (phase !== 2'b00 || active_way !== 2'd0 || light !== L_G0) begin
        fails++;
        $display("FAIL idle c%0d phase/active/light got %b/%0d/%b want 00/0/%b",
                 c, phase, active_way, light, L_G0);
      end
      step();
    end
  endtask

  task automatic test_min_green();
    logic [5:0] el;
    logic [1:0] ep;
    logic [1:0] ea;
    do_reset(3'b010);
    for (int c = 0; c < 8; c++) begin
      if (c < 4)      begin el = L_G0; ep = 2'b00; ea = 2'd0; end
      else if (c < 6) begin el = L_Y0; ep = 2'b01; ea = 2'd0; end
      else if (c == 6) begin el = L_AR; ep = 2'b10; ea = 2'd0; end
      else            begin el = L_G1; ep = 2'b00; ea = 2'd1; end
      tests++;
      if (light !== el) begin fails++; $display("FAIL min_green c%0d light got %b want %b", c, light, el); end
      tests++;
      if (phase !== ep) begin fails++; $display("FAIL min_green c%0d phase got %b want %b", c, phase, ep); end
      tests++;
      if (active_way !== ea) begin fails++; $display("FAIL min_green c%0d active got %0d want %0d", c, active_way, ea); end
      step();
    end
  endtask

  task automatic test_max_green();
    logic [1:0] ep;
    do_reset(3'b011);
    for (int c = 0; c < 12; c++) begin
      if (c < 8)       ep = 2'b00;
      else if (c < 10) ep = 2'b01;
      else if (c == 10) ep = 2'b10;
      else             ep = 2'b00;
      tests++;
      if (phase !== ep) begin fails++; $display("FAIL max_green c%0d phase got %b want %b", c, phase, ep); end
      if (c == 11) begin
        tests++;
        if (active_way !== 2'd1 || light !== L_G1) begin
          fails++;
          $display("FAIL max_green c11 active/light got %0d/%b want 1/%b", active_way, light, L_G1);
        end
      end
      step();
    end
  endtask

  task automatic test_skip_idle();
    do_reset(3'b101);
    for (int c = 0; c < 11; c++) step();
    tests++;
    if (phase !== 2'b00 || active_way !== 2'd2 || light !== L_G2) begin
      fails++;
      $display("FAIL skip_idle phase/active/light got %b/%0d/%b want 00/2/%b",
               phase, active_way, light, L_G2);
    end
  endtask

  task automatic test_back_to_back();
    do_reset(3'b111);
    for (int c = 0; c <= 33; c++) begin
      if (c == 10 || c == 21 || c == 32) begin
        tests++;
        if (phase !== 2'b10 || light !== L_AR) begin
          fails++;
          $display("FAIL b2b c%0d phase/light got %b/%b want 10/%b", c, phase, light, L_AR);
        end
      end
      if (c == 11) begin
        tests++;
        if (active_way !== 2'd1 || light !== L_G1) begin fails++; $display("FAIL b2b c11 active/light got %0d/%b want 1/%b", active_way, light, L_G1); end
      end
      if (c == 22) begin
        tests++;
        if (active_way !== 2'd2 || light !== L_G2) begin fails++; $display("FAIL b2b c22 active/light got %0d/%b want 2/%b", active_way, light, L_G2); end
      end
      if (c == 33) begin
        tests++;
        if (active_way !== 2'd0 || light !== L_G0) begin fails++; $display("FAIL b2b c33 active/light got %0d/%b want 0/%b", active_way, light, L_G0); end
      end
      step();
    end
  endtask

  task automatic test_flash();
    logic [5:0] el;
    do_reset(3'b010);
    for (int c = 0; c < 4; c++) step();
    tests++;
    if (phase !== 2'b01) begin fails++; $display("FAIL flash pre c4 phase got %b want 01", phase); end
    flash = 1'b1;
    step();
    for (int c = 5; c <= 13; c++) begin
      el = (c >= 8 && c <= 10) ? L_FO : L_FY;
      tests++;
      if (light !== el || phase !== 2'b11) begin
        fails++;
        $display("FAIL flash c%0d light/phase got %b/%b want %b/11", c, light, phase, el);
      end
      tests++;
      if (active_way !== 2'd0) begin fails++; $display("FAIL flash c%0d active got %0d want 0", c, active_way); end
      if (c < 13) step();
    end
    flash = 1'b0;
    step();
    tests++;
    if (phase !== 2'b10 || light !== L_AR) begin
      fails++;
      $display("FAIL flash_exit allred phase/light got %b/%b want 10/%b", phase, light, L_AR);
    end
    step();
    tests++;
    if (phase !== 2'b00 || active_way !== 2'd0 || light !== L_G0) begin
      fails++;
      $display("FAIL flash_exit green phase/active/light got %b/%0d/%b want 00/0/%b",
               phase, active_way, light, L_G0);
    end
    for (int c = 0; c < 4; c++) step();
    tests++;
    if (phase !== 2'b01) begin fails++; $display("FAIL flash_exit yellow phase got %b want 01", phase); end
    for (int c = 0; c < 3; c++) step();
    tests++;
    if (phase !== 2'b00 || active_way !== 2'd1) begin
      fails++;
      $display("FAIL flash_exit rr_resume phase/active got %b/%0d want 00/1", phase, active_way);
    end
  endtask

  task automatic test_reset_mid();
    logic [1:0] ep;
    do_reset(3'b100);
    for (int c = 0; c < 7; c++) step();
    tests++;
    if (active_way !== 2'd2 || phase !== 2'b00) begin
      fails++;
      $display("FAIL rst_mid c7 active/phase got %0d/%b want 2/00", active_way, phase);
    end
    req = 3'b001;
    for (int c = 7; c < 13; c++) step();
    tests++;
    if (phase !== 2'b10 || active_way !== 2'd2) begin
      fails++;
      $display("FAIL rst_mid c13 phase/active got %b/%0d want 10/2", phase, active_way);
    end
    rst = 1'b1;
    req = 3'b010;
    step();
    tests++;
    if (phase !== 2'b00 || active_way !== 2'd0 || light !== L_G0) begin
      fails++;
      $display("FAIL rst_mid after phase/active/light got %b/%0d/%b want 00/0/%b",
               phase, active_way, light, L_G0);
    end
    rst = 1'b0;
    for (int k = 0; k <= 4; k++) begin
      ep = (k < 4) ? 2'b00 : 2'b01;
      tests++;
      if (phase !== ep) begin fails++; $display("FAIL rst_mid green k%0d phase got %b want %b", k, phase, ep); end
      step();
    end
  endtask

  initial begin
    rst = 1'b1; req = 3'b000; flash = 1'b0;
    test_reset();
    test_idle_hold();
    test_min_green();
    test_max_green();
    test_skip_idle();
    test_back_to_back();
    test_flash();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
